// File: rtl/regfile_sb.sv
// Parametrised register file with one write port, two combinational read ports,
// optional write-to-read bypass and a per-register busy scoreboard for issue/writeback.
module regfile_sb #(
  parameter int DATAWIDTH = 32,
  parameter int ADDRWIDTH = 5,
  parameter int ZERO_X0   = 1,
  parameter int BYPASS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ADDRWIDTH-1:0] readReg1,
  input  logic [ADDRWIDTH-1:0] readReg2,
  input  logic [ADDRWIDTH-1:0] writeReg,
  input  logic [DATAWIDTH-1:0] writeData,
  input  logic                 write,
  input  logic                 reserve,
  input  logic [ADDRWIDTH-1:0] reserveReg,
  output logic [DATAWIDTH-1:0] readData1,
  output logic [DATAWIDTH-1:0] readData2,
  output logic                 busy1,
  output logic                 busy2,
  output logic [ADDRWIDTH:0]   busyCount
);

  localparam int NREG = 2 ** ADDRWIDTH;
  localparam bit ZX   = (ZERO_X0 != 0);
  localparam bit BP   = (BYPASS != 0);

  logic [DATAWIDTH-1:0] regs [NREG];
  logic [NREG-1:0]      busy;
  logic [NREG-1:0]      busy_next;
  logic [ADDRWIDTH:0]   count_next;
  logic                 write_en;
  logic                 hit1;
  logic                 hit2;

  function automatic logic is_x0(input logic [ADDRWIDTH-1:0] a);
    return ZX && (a == '0);
  endfunction

  function automatic logic [ADDRWIDTH:0] popcount(input logic [NREG-1:0] v);
    logic [ADDRWIDTH:0] c;
    c = '0;
    for (int i = 0; i < NREG; i++) begin
      if (v[i]) c = c + (ADDRWIDTH+1)'(1);
    end
    return c;
  endfunction

  assign write_en = write && !is_x0(writeReg);

  // Reserve beats release on the same register so back-to-back producers stay tracked.
  always_comb begin
    busy_next = busy;
    for (int r = 0; r < NREG; r++) begin
      if (reserve && (reserveReg == ADDRWIDTH'(r)))
        busy_next[r] = 1'b1;
      else if (write && (writeReg == ADDRWIDTH'(r)))
        busy_next[r] = 1'b0;
    end
    if (ZX) busy_next[0] = 1'b0;
  end

  assign count_next = popcount(busy_next);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      busy      <= '0;
      busyCount <= '0;
    end else begin
      if (write_en) regs[writeReg] <= writeData;
      busy      <= busy_next;
      busyCount <= count_next;
    end
  end

  assign hit1 = BP && write && (writeReg == readReg1);
  assign hit2 = BP && write && (writeReg == readReg2);

  // A write presented this cycle overrides both stored data and the pending flag.
  always_comb begin
    readData1 = regs[readReg1];
    busy1     = busy[readReg1];
    if (hit1) begin
      readData1 = writeData;
      busy1     = 1'b0;
    end
    if (rst || is_x0(readReg1)) begin
      readData1 = '0;
      busy1     = 1'b0;
    end
  end

  always_comb begin
    readData2 = regs[readReg2];
    busy2     = busy[readReg2];
    if (hit2) begin
      readData2 = writeData;
      busy2     = 1'b0;
    end
    if (rst || is_x0(readReg2)) begin
      readData2 = '0;
      busy2     = 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: default configuration (bypass, zero x0) and a
// small 16x8 configuration without bypass or zeroed x0.
module tb_regfile_sb;

  logic clk;
  logic clk_run;
  logic rst;

  // Instance A: DATAWIDTH=32, ADDRWIDTH=5, ZERO_X0=1, BYPASS=1
  logic [4:0]  a_r1, a_r2, a_wreg, a_rreg;
  logic [31:0] a_wdata, a_rd1, a_rd2;
  logic        a_wr, a_rsv, a_b1, a_b2;
  logic [5:0]  a_cnt;

  // Instance B: DATAWIDTH=16, ADDRWIDTH=3, ZERO_X0=0, BYPASS=0
  logic [2:0]  b_r1, b_r2, b_wreg, b_rreg;
  logic [15:0] b_wdata, b_rd1, b_rd2;
  logic        b_wr, b_rsv, b_b1, b_b2;
  logic [3:0]  b_cnt;

  int n_vec;
  int n_fail;

  regfile_sb dut_a (
    .clk(clk), .rst(rst),
    .readReg1(a_r1), .readReg2(a_r2), .writeReg(a_wreg), .writeData(a_wdata),
    .write(a_wr), .reserve(a_rsv), .reserveReg(a_rreg),
    .readData1(a_rd1), .readData2(a_rd2), .busy1(a_b1), .busy2(a_b2),
    .busyCount(a_cnt)
  );

  regfile_sb #(.DATAWIDTH(16), .ADDRWIDTH(3), .ZERO_X0(0), .BYPASS(0)) dut_b (
    .clk(clk), .rst(rst),
    .readReg1(b_r1), .readReg2(b_r2), .writeReg(b_wreg), .writeData(b_wdata),
    .write(b_wr), .reserve(b_rsv), .reserveReg(b_rreg),
    .readData1(b_rd1), .readData2(b_rd2), .busy1(b_b1), .busy2(b_b2),
    .busyCount(b_cnt)
  );

  initial begin
    clk = 1'b0;
    wait (clk_run);
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        wr;
    logic [4:0]  wreg;
    logic [31:0] wdata;
    logic        rsv;
    logic [4:0]  rreg;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic [31:0] e1;
    logic [31:0] e2;
    logic        eb1;
    logic        eb2;
    logic [5:0]  ecnt;
  } vec_t;

  vec_t tbl [17];

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  // Packs instance A outputs as {rd1, rd2, b1, b2, cnt}.
  function automatic logic [127:0] a_pack();
    return {48'd0, a_rd1, a_rd2, a_b1, a_b2, a_cnt};
  endfunction

  function automatic logic [127:0] a_exp(input logic [31:0] e1, input logic [31:0] e2,
                                         input logic eb1, input logic eb2, input logic [5:0] c);
    return {48'd0, e1, e2, eb1, eb2, c};
  endfunction

  function automatic logic [127:0] b_pack();
    return {82'd0, b_rd1, b_rd2, b_b1, b_b2, b_cnt};
  endfunction

  function automatic logic [127:0] b_exp(input logic [15:0] e1, input logic [15:0] e2,
                                         input logic eb1, input logic eb2, input logic [3:0] c);
    return {82'd0, e1, e2, eb1, eb2, c};
  endfunction

  task automatic a_idle();
    a_wr = 1'b0; a_wreg = 5'd0; a_wdata = 32'd0; a_rsv = 1'b0; a_rreg = 5'd0;
  endtask

  task automatic b_idle();
    b_wr = 1'b0; b_wreg = 3'd0; b_wdata = 16'd0; b_rsv = 1'b0; b_rreg = 3'd0;
  endtask

  initial begin
    n_vec = 0;
    n_fail = 0;
    clk_run = 1'b0;
    rst = 1'b0;
    a_idle(); a_r1 = 5'd0; a_r2 = 5'd0;
    b_idle(); b_r1 = 3'd0; b_r2 = 3'd0;

    //                 wr    wreg   wdata          rsv   rreg   r1     r2     e1             e2             eb1   eb2   ecnt
    tbl[0]  = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0,        1'b0, 1'b0, 6'd0};
    tbl[1]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0, 6'd0};
    tbl[2]  = '{1'b1, 5'd0, 32'h12345678, 1'b0, 5'd0, 5'd0, 5'd5, 32'h0,        32'hDEADBEEF, 1'b0, 1'b0, 6'd0};
    tbl[3]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd0, 5'd5, 32'h0,        32'hDEADBEEF, 1'b0, 1'b0, 6'd0};
    tbl[4]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd7, 5'd7, 5'd5, 32'h0,        32'hDEADBEEF, 1'b0, 1'b0, 6'd0};
    tbl[5]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd7, 5'd5, 32'h0,        32'hDEADBEEF, 1'b1, 1'b0, 6'd1};
    tbl[6]  = '{1'b1, 5'd7, 32'h55,       1'b0, 5'd0, 5'd7, 5'd7, 32'h55,       32'h55,       1'b0, 1'b0, 6'd1};
    tbl[7]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd7, 5'd7, 32'h55,       32'h55,       1'b0, 1'b0, 6'd0};
    tbl[8]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd9, 5'd9, 5'd7, 32'h0,        32'h55,       1'b0, 1'b0, 6'd0};
    tbl[9]  = '{1'b1, 5'd9, 32'h99,       1'b1, 5'd9, 5'd9, 5'd7, 32'h99,       32'h55,       1'b0, 1'b0, 6'd1};
    tbl[10] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd9, 5'd7, 32'h99,       32'h55,       1'b1, 1'b0, 6'd1};
    tbl[11] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd0, 5'd0, 5'd9, 32'h0,        32'h99,       1'b0, 1'b1, 6'd1};
    tbl[12] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd0, 5'd9, 32'h0,        32'h99,       1'b0, 1'b1, 6'd1};
    tbl[13] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd9, 5'd9, 5'd0, 32'h99,       32'h0,        1'b1, 1'b0, 6'd1};
    tbl[14] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd9, 5'd0, 32'h99,       32'h0,        1'b1, 1'b0, 6'd1};
    tbl[15] = '{1'b1, 5'd9, 32'h1234,     1'b0, 5'd0, 5'd7, 5'd9, 32'h55,       32'h1234,     1'b0, 1'b0, 6'd1};
    tbl[16] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd9, 5'd7, 32'h1234,     32'h55,       1'b0, 1'b0, 6'd0};

    // Asynchronous reset with no clock running
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      a_r1 = 5'(i);
      a_r2 = 5'(31 - i);
      #1 check($sformatf("reset_read_x%0d", i), a_pack(), a_exp(32'h0, 32'h0, 1'b0, 1'b0, 6'd0));
    end
    check("reset_b", b_pack(), b_exp(16'h0, 16'h0, 1'b0, 1'b0, 4'd0));

    clk_run = 1'b1;

    // Table-driven vectors on instance A; checks sample the pre-edge combinational outputs
    for (int v = 0; v < 17; v++) begin
      @(negedge clk);
      a_wr = tbl[v].wr; a_wreg = tbl[v].wreg; a_wdata = tbl[v].wdata;
      a_rsv = tbl[v].rsv; a_rreg = tbl[v].rreg;
      a_r1 = tbl[v].r1; a_r2 = tbl[v].r2;
      #2 check($sformatf("vec%0d", v), a_pack(),
               a_exp(tbl[v].e1, tbl[v].e2, tbl[v].eb1, tbl[v].eb2, tbl[v].ecnt));
    end

    // Mid-operation async reset: x3 reserved+written on the same edge, then x4 reserved
    @(negedge clk);
    a_idle(); a_rsv = 1'b1; a_rreg = 5'd3; a_wr = 1'b1; a_wreg = 5'd3; a_wdata = 32'hAA;
    a_r1 = 5'd3; a_r2 = 5'd4;
    #2 check("midrst_setup0", a_pack(), a_exp(32'hAA, 32'h0, 1'b0, 1'b0, 6'd0));
    @(negedge clk);
    a_idle(); a_rsv = 1'b1; a_rreg = 5'd4;
    #2 check("midrst_setup1", a_pack(), a_exp(32'hAA, 32'h0, 1'b1, 1'b0, 6'd1));
    @(negedge clk);
    a_idle();
    #2 check("midrst_before", a_pack(), a_exp(32'hAA, 32'h0, 1'b1, 1'b1, 6'd2));
    #1 rst = 1'b1;
    a_wr = 1'b1; a_wreg = 5'd3; a_wdata = 32'h77; a_rsv = 1'b1; a_rreg = 5'd5;
    #1 check("midrst_during", a_pack(), a_exp(32'h0, 32'h0, 1'b0, 1'b0, 6'd0));
    @(negedge clk);
    rst = 1'b0;
    a_idle();
    #2 check("midrst_release", a_pack(), a_exp(32'h0, 32'h0, 1'b0, 1'b0, 6'd0));
    @(negedge clk);
    a_r2 = 5'd5;
    #2 check("midrst_after_edge", a_pack(), a_exp(32'h0, 32'h0, 1'b0, 1'b0, 6'd0));

    // Instance B: no bypass, x0 is an ordinary register
    @(negedge clk);
    b_idle(); b_wr = 1'b1; b_wreg = 3'd0; b_wdata = 16'hBEEF; b_r1 = 3'd0; b_r2 = 3'd1;
    #2 check("b_x0_write_same", b_pack(), b_exp(16'h0, 16'h0, 1'b0, 1'b0, 4'd0));
    @(negedge clk);
    b_idle();
    #2 check("b_x0_write_next", b_pack(), b_exp(16'hBEEF, 16'h0, 1'b0, 1'b0, 4'd0));
    @(negedge clk);
    b_idle(); b_rsv = 1'b1; b_rreg = 3'd2; b_r1 = 3'd2;
    #2 check("b_reserve_same", b_pack(), b_exp(16'h0, 16'h0, 1'b0, 1'b0, 4'd0));
    @(negedge clk);
    b_idle();
    #2 check("b_reserve_next", b_pack(), b_exp(16'h0, 16'h0, 1'b1, 1'b0, 4'd1));
    @(negedge clk);
    b_idle(); b_wr = 1'b1; b_wreg = 3'd2; b_wdata = 16'h0022;
    #2 check("b_release_same", b_pack(), b_exp(16'h0, 16'h0, 1'b1, 1'b0, 4'd1));
    @(negedge clk);
    b_idle();
    #2 check("b_release_next", b_pack(), b_exp(16'h0022, 16'h0, 1'b0, 1'b0, 4'd0));
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      b_idle(); b_rsv = 1'b1; b_rreg = 3'(i);
    end
    @(negedge clk);
    b_idle(); b_r1 = 3'd0; b_r2 = 3'd7;
    #2 check("b_all_busy", b_pack(), b_exp(16'hBEEF, 16'h0, 1'b1, 1'b1, 4'd8));
    @(negedge clk);
    b_idle(); b_wr = 1'b1; b_wreg = 3'd0; b_wdata = 16'h0001;
    #2 check("b_full_release_same", b_pack(), b_exp(16'hBEEF, 16'h0, 1'b1, 1'b1, 4'd8));
    @(negedge clk);
    b_idle();
    #2 check("b_full_release_next", b_pack(), b_exp(16'h0001, 16'h0, 1'b0, 1'b1, 4'd7));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
